dct_8pt_stream: RTL and testbench



---
 rtl/dct_pkg.sv | 33 +++
 rtl/dct_dot8.sv | 33 +++
 rtl/dct_8pt_stream.sv | 124 ++++++++++++
 tb/tb_dct_8pt_stream.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants for the streaming 8-point DCT-II engine.
// Holds the coefficient format, the accumulator width, the 8x8 orthonormal
// cosine table C[k][n] scaled by 2^14, and the capture/output state type.
package dct_pkg;

  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 14;
  localparam int ACC_W     = 44;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Half an output LSB, added before the arithmetic shift for round half-up.
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) << (COEF_FRAC - 1);

  // Row k selects output coefficient Y_k, column n weights input sample x[n].
  localparam coef_t C_TABLE [8][8] = '{
    '{ 16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793},
    '{ 16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035},
    '{ 16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568},
    '{ 16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811},
    '{ 16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793},
    '{ 16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551},
    '{ 16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135},
    '{ 16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598}
  };

  // FILL: no complete block captured yet since reset; STREAM: hold bank is valid.
  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } dct_state_e;

endpackage

// File: rtl/dct_dot8.sv
// Combinational 8-term signed dot product: one DCT coefficient row against
// the held block of samples. Eight multipliers feed a three-level adder tree.
module dct_dot8 import dct_pkg::*; #(
  parameter int BITS = 25
) (
  input  logic signed [BITS-1:0]  x [8],
  input  logic [2:0]              k,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [BITS+COEF_W-1:0] prod [8];
  logic signed [ACC_W-1:0]       level1 [4];
  logic signed [ACC_W-1:0]       level2 [2];

  // Multiply each held sample by the coefficient of row k in its column.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      prod[n] = x[n] * C_TABLE[k][n];
    end
  end

  // Balanced adder tree, sign-extending every product to the accumulator width.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      level1[i] = ACC_W'(prod[2*i]) + ACC_W'(prod[2*i+1]);
    end
    for (int i = 0; i < 2; i++) begin
      level2[i] = level1[2*i] + level1[2*i+1];
    end
    sum = level2[0] + level2[1];
  end

endmodule

// File: rtl/dct_8pt_stream.sv
// Streaming 8-point orthonormal DCT-II, one sample in and one coefficient out
// per clock with no bubbles. Samples are captured into an input bank; when x7
// arrives the block moves to a hold bank, which the output phase reads while
// the next block is captured. Y_k is selected by the free-running sample
// counter, so Y0 of a block lines up with x0 of the following block.
// Build option: define DCT_SAT_EN to clamp out-of-range results to the
// signed BITS range; otherwise the low BITS bits are kept (wrap).
module dct_8pt_stream import dct_pkg::*; #(
  parameter int BITS = 25
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] in,
  output logic [BITS-1:0] O,
  output logic            finish
);

`ifdef DCT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
`endif

  logic [2:0]              sample_cnt;
  logic signed [BITS-1:0]  in_bank [7];
  logic signed [BITS-1:0]  hold_bank [8];
  dct_state_e              state;
  dct_state_e              next_state;
  logic                    out_en;
  logic                    block_start;
  logic signed [ACC_W-1:0] dot_sum;
  logic signed [ACC_W-1:0] acc_round;
  logic signed [ACC_W-1:0] acc_shift;
  logic [BITS-1:0]         y_next;

  // Free-running sample index; doubles as the output coefficient index k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= 3'd0;
    end else begin
      sample_cnt <= sample_cnt + 3'd1;
    end
  end

  // Capture x0..x6, then hand the whole block (with x7 straight from the port) to the hold bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin
        in_bank[i] <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        hold_bank[i] <= '0;
      end
    end else if (sample_cnt == 3'd7) begin
      for (int i = 0; i < 7; i++) begin
        hold_bank[i] <= in_bank[i];
      end
      hold_bank[7] <= in;
    end else begin
      in_bank[sample_cnt] <= in;
    end
  end

  // State register: remembers whether a complete block has been held since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
    end else begin
      state <= next_state;
    end
  end

  // Leave FILL on the edge that captures the first x7; streaming then never stops.
  always_comb begin
    next_state = state;
    if (state == ST_FILL && sample_cnt == 3'd7) begin
      next_state = ST_STREAM;
    end
  end

  // Output enables: results are registered only once the hold bank is valid, and k=0 marks a block.
  always_comb begin
    out_en      = (state == ST_STREAM);
    block_start = (state == ST_STREAM) && (sample_cnt == 3'd0);
  end

  dct_dot8 #(
    .BITS (BITS)
  ) u_dot8 (
    .x   (hold_bank),
    .k   (sample_cnt),
    .sum (dot_sum)
  );

  // Round half-up, drop the coefficient fraction, then reduce to the output width.
  always_comb begin
    acc_round = dot_sum + ROUND_HALF;
    acc_shift = acc_round >>> COEF_FRAC;
`ifdef DCT_SAT_EN
    if (acc_shift > SAT_MAX) begin
      y_next = {1'b0, {(BITS-1){1'b1}}};
    end else if (acc_shift < SAT_MIN) begin
      y_next = {1'b1, {(BITS-1){1'b0}}};
    end else begin
      y_next = acc_shift[BITS-1:0];
    end
`else
    y_next = acc_shift[BITS-1:0];
`endif
  end

  // The single pipeline register: coefficient output plus the block-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O      <= '0;
      finish <= 1'b0;
    end else begin
      finish <= block_start;
      if (out_en) begin
        O <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_dct_8pt_stream.sv
// Directed self-checking bench for dct_8pt_stream. Blocks of known samples are
// streamed back-to-back and every output cycle is compared with hand-computed
// coefficients; a mid-block reset and a fresh stream follow.
module tb_dct_8pt_stream;

  localparam int BITS = 25;

`ifdef DCT_SAT_EN
  localparam int OVF_Y0 = 16777215;
`else
  localparam int OVF_Y0 = -10925526;
`endif

  // Block kinds used to build stimulus and expectations.
  localparam int K_ZERO = 0;
  localparam int K_DC   = 1;
  localparam int K_IMP  = 2;
  localparam int K_NDC  = 3;
  localparam int K_OVF  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [BITS-1:0] in_s;
  logic [BITS-1:0] o_s;
  logic            finish_s;

  int checks = 0;
  int errors = 0;
  int stim [128];
  int exp_tab [16][8];

  dct_8pt_stream #(
    .BITS (BITS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in_s),
    .O      (o_s),
    .finish (finish_s)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int blockSample(input int kind, input int n);
    case (kind)
      K_DC:    return 100;
      K_IMP:   return (n == 0) ? 1000 : 0;
      K_NDC:   return -100;
      K_OVF:   return 8000000;
      default: return 0;
    endcase
  endfunction

  function automatic int blockCoef(input int kind, input int k);
    int imp_y [8];
    imp_y = '{354, 490, 462, 416, 354, 278, 191, 98};
    case (kind)
      K_DC:    return (k == 0) ? 283 : 0;
      K_IMP:   return imp_y[k];
      K_NDC:   return (k == 0) ? -283 : 0;
      K_OVF:   return (k == 0) ? OVF_Y0 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic setBlock(input int b, input int kind);
    for (int n = 0; n < 8; n++) begin
      stim[8*b+n]   = blockSample(kind, n);
      exp_tab[b][n] = blockCoef(kind, n);
    end
  endtask

  // Release reset (if held) and stream samples; Y_k of block b is seen at negedge 8b+9+k.
  task automatic applyStimulus(input string run, input int n_samp, input int n_cycles);
    int exp_o;
    int exp_f;
    int b;
    int k;
    for (int j = 0; j < n_cycles; j++) begin
      @(negedge clk);
      exp_o = 0;
      exp_f = 0;
      if (j >= 9) begin
        b     = (j - 9) / 8;
        k     = (j - 9) % 8;
        exp_o = exp_tab[b][k];
        exp_f = (k == 0) ? 1 : 0;
      end
      checkOutput($sformatf("%s O@%0d", run, j), $signed(o_s), exp_o);
      checkOutput($sformatf("%s finish@%0d", run, j), int'(finish_s), exp_f);
      rst_n = 1'b1;
      in_s  = (j < n_samp) ? BITS'(stim[j]) : '0;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    in_s  = '0;
    #2 rst_n = 1'b0;

    // Reset state.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("reset O", $signed(o_s), 0);
      checkOutput("reset finish", int'(finish_s), 0);
    end

    // DC, impulse->DC streaming, negative DC, overflow, then a partial block of 5.
    setBlock(0, K_DC);
    setBlock(1, K_IMP);
    setBlock(2, K_DC);
    setBlock(3, K_NDC);
    setBlock(4, K_OVF);
    setBlock(5, K_IMP);
    setBlock(6, K_DC);
    setBlock(7, K_IMP);
    for (int i = 64; i < 69; i++) begin
      stim[i] = 55;
    end
    applyStimulus("run1", 69, 69);

    // Mid-block reset while block 7 is being output.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset O", $signed(o_s), 0);
    checkOutput("midreset finish", int'(finish_s), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("midreset hold O", $signed(o_s), 0);
      checkOutput("midreset hold finish", int'(finish_s), 0);
    end

    // Fresh DC block after release; the partial block must be gone.
    for (int b = 0; b < 16; b++) begin
      setBlock(b, K_ZERO);
    end
    setBlock(0, K_DC);
    applyStimulus("run2", 16, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
